// File: rtl/dct_block_scheduler.sv
// Sequences blocks through load -> DCT kick -> wait -> output handshake for a run of N blocks.
// Optional WAIT_DCT watchdog is built only when DCT_SCHED_TIMEOUT_EN is defined.
module dct_block_scheduler #(
  parameter int unsigned MAX_BLOCK_NUM  = 32,
  parameter int unsigned MAX_PIXEL_NUM  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  block_num,
  output logic        busy,
  output logic        load,
  output logic [4:0]  block_index,
  output logic [10:0] base_addr,
  output logic        dct_start,
  input  logic        dct_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWaitDct,
    StOutput,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [10:0] base_q, base_d;
  logic [5:0]  num_q, num_d;
  logic        start_ok;
  logic        last_block;
  logic        timeout_hit;

  assign start_ok   = (block_num != 6'd0) && (32'(block_num) <= MAX_BLOCK_NUM);
  assign last_block = ({1'b0, idx_q} == (num_q - 6'd1));

`ifdef DCT_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          error_q, error_d;

  assign timeout_hit = (state_q == StWaitDct) && !dct_done &&
                       (32'(wd_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    wd_d    = '0;
    error_d = error_q | timeout_hit;
    if (state_q == StWaitDct && !dct_done) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    num_d   = num_q;
    unique case (state_q)
      StIdle: begin
        if (start && start_ok) begin
          num_d   = block_num;
          idx_d   = '0;
          base_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad:    state_d = StKick;
      StKick:    state_d = StWaitDct;
      StWaitDct: begin
        if (dct_done) begin
          state_d = StOutput;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StOutput: begin
        if (out_ready) begin
          if (last_block) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + 5'd1;
            base_d  = 11'(32'(idx_d) * MAX_PIXEL_NUM);
            state_d = StLoad;
          end
        end
      end
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      num_q   <= num_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign load        = (state_q == StLoad);
  assign dct_start   = (state_q == StKick);
  assign out_valid   = (state_q == StOutput);
  assign done        = (state_q == StFinish);
  assign block_index = idx_q;
  assign base_addr   = base_q;

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Directed bench for dct_block_scheduler; timeout scenario runs only with DCT_SCHED_TIMEOUT_EN.
module tb_dct_block_scheduler;

  logic        clock, reset, start, dct_done, out_ready;
  logic [5:0]  block_num;
  logic        busy, load, dct_start, out_valid, done, error;
  logic [4:0]  block_index;
  logic [10:0] base_addr;
  logic [4:0]  outs;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  logic [10:0] load_addr [0:63];

  dct_block_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .block_num  (block_num),
    .busy       (busy),
    .load       (load),
    .block_index(block_index),
    .base_addr  (base_addr),
    .dct_start  (dct_start),
    .dct_done   (dct_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done),
    .error      (error)
  );

  assign outs = {busy, load, dct_start, out_valid, done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (load) begin
      if (load_cnt < 64) load_addr[load_cnt] = base_addr;
      load_cnt = load_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; block_num = 6'd3;
    tick();
    tick();
    n_checks++;
    if (outs !== 5'b00000) $display("FAIL reset_outs: got %b want 00000", outs);
    else n_pass++;
    n_checks++;
    if ({block_index, base_addr, error} !== 17'd0)
      $display("FAIL reset_regs: got idx=%0d addr=%0d err=%b want 0", block_index, base_addr, error);
    else n_pass++;
    start = 1'b0; reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_prio_start: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_three_blocks();
    int l0 = load_cnt;
    int d0 = done_cnt;
    block_num = 6'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n_checks++;
      if (outs !== 5'b11000 || base_addr !== 11'(b * 64) || block_index !== 5'(b))
        $display("FAIL three_load%0d: got outs=%b addr=%0d idx=%0d want 11000 %0d %0d",
                 b, outs, base_addr, block_index, b * 64, b);
      else n_pass++;
      tick();
      n_checks++;
      if (outs !== 5'b10100) $display("FAIL three_kick%0d: got %b want 10100", b, outs);
      else n_pass++;
      repeat (5) tick();
      n_checks++;
      if (outs !== 5'b10000) $display("FAIL three_wait%0d: got %b want 10000", b, outs);
      else n_pass++;
      dct_done = 1'b1;
      tick();
      dct_done = 1'b0;
      n_checks++;
      if (outs !== 5'b10010) $display("FAIL three_out%0d: got %b want 10010", b, outs);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (outs !== 5'b10001) $display("FAIL three_done: got %b want 10001", outs);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 5'b00000) $display("FAIL three_idle: got %b want 00000", outs);
    else n_pass++;
    n_checks++;
    if (load_cnt - l0 !== 3 || done_cnt - d0 !== 1)
      $display("FAIL three_counts: got loads=%0d dones=%0d want 3 1", load_cnt - l0, done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (load_addr[l0] !== 11'd0 || load_addr[l0+1] !== 11'd64 || load_addr[l0+2] !== 11'd128)
      $display("FAIL three_addrs: got %0d %0d %0d want 0 64 128",
               load_addr[l0], load_addr[l0+1], load_addr[l0+2]);
    else n_pass++;
  endtask

  task automatic test_invalid_start();
    int l0 = load_cnt;
    block_num = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || load !== 1'b0) $display("FAIL zero_start: got busy=%b load=%b want 0 0", busy, load);
    else n_pass++;
    block_num = 6'd33; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || load_cnt - l0 !== 0)
      $display("FAIL over_start: got busy=%b loads=%0d want 0 0", busy, load_cnt - l0);
    else n_pass++;
    block_num = 6'd32; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (outs !== 5'b11000) $display("FAIL max_start: got %b want 11000", outs);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_backpressure();
    int valid_cycles = 0;
    block_num = 6'd2; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1 && block_index === 5'd0) valid_cycles++;
      tick();
    end
    out_ready = 1'b1;
    if (out_valid === 1'b1 && block_index === 5'd0) valid_cycles++;
    n_checks++;
    if (valid_cycles !== 5) $display("FAIL bp_valid_hold: got %0d want 5", valid_cycles);
    else n_pass++;
    tick();
    n_checks++;
    if (outs !== 5'b11000 || block_index !== 5'd1 || base_addr !== 11'd64)
      $display("FAIL bp_advance: got outs=%b idx=%0d addr=%0d want 11000 1 64",
               outs, block_index, base_addr);
    else n_pass++;
    tick();
    tick();
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    tick();
    n_checks++;
    if (outs !== 5'b10001) $display("FAIL bp_done: got %b want 10001", outs);
    else n_pass++;
    tick();
  endtask

  task automatic test_ignored_inputs();
    int l0 = load_cnt;
    int d0 = done_cnt;
    out_ready = 1'b1; dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    n_checks++;
    if (outs !== 5'b00000) $display("FAIL idle_dct_done: got %b want 00000", outs);
    else n_pass++;
    block_num = 6'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; block_num = 6'd1;
    tick();
    start = 1'b0;
    n_checks++;
    if (outs !== 5'b10000 || block_index !== 5'd0)
      $display("FAIL wait_start_ignored: got outs=%b idx=%0d want 10000 0", outs, block_index);
    else n_pass++;
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    tick();
    n_checks++;
    if (outs !== 5'b11000 || block_index !== 5'd1)
      $display("FAIL latched_num_kept: got outs=%b idx=%0d want 11000 1", outs, block_index);
    else n_pass++;
    tick();
    tick();
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    tick();
    n_checks++;
    if (outs !== 5'b10001) $display("FAIL ign_done: got %b want 10001", outs);
    else n_pass++;
    tick();
    n_checks++;
    if (load_cnt - l0 !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0)
      $display("FAIL ign_counts: got loads=%0d dones=%0d busy=%b want 2 1 0",
               load_cnt - l0, done_cnt - d0, busy);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    int d0 = done_cnt;
    block_num = 6'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (outs !== 5'b10000 || block_index !== 5'd1)
      $display("FAIL rst_in_wait1: got outs=%b idx=%0d want 10000 1", outs, block_index);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (outs !== 5'b00000 || block_index !== 5'd0 || base_addr !== 11'd0)
      $display("FAIL rst_abort: got outs=%b idx=%0d addr=%0d want 00000 0 0",
               outs, block_index, base_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (done_cnt - d0 !== 0) $display("FAIL rst_no_done: got %0d want 0", done_cnt - d0);
    else n_pass++;
    block_num = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (outs !== 5'b11000 || base_addr !== 11'd0)
      $display("FAIL rst_restart_load: got outs=%b addr=%0d want 11000 0", outs, base_addr);
    else n_pass++;
    tick();
    tick();
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    tick();
    n_checks++;
    if (outs !== 5'b10001 || done_cnt - d0 !== 0)
      $display("FAIL rst_restart_done: got outs=%b prior_dones=%0d want 10001 0", outs, done_cnt - d0);
    else n_pass++;
    tick();
  endtask

`ifdef DCT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int d0 = done_cnt;
    block_num = 6'd1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    repeat (255) tick();
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0)
      $display("FAIL to_before: got busy=%b err=%b want 1 0", busy, error);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || error !== 1'b1)
      $display("FAIL to_fire: got busy=%b err=%b want 0 1", busy, error);
    else n_pass++;
    dct_done = 1'b1;
    tick();
    dct_done = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (error !== 1'b1 || done_cnt - d0 !== 0)
      $display("FAIL to_sticky: got err=%b dones=%0d want 1 0", error, done_cnt - d0);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (error !== 1'b0) $display("FAIL to_clear: got err=%b want 0", error);
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; dct_done = 1'b0; out_ready = 1'b0; block_num = 6'd0;
    test_reset();
    test_three_blocks();
    test_invalid_start();
    test_backpressure();
    test_ignored_inputs();
    test_midrun_reset();
`ifdef DCT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_block_scheduler.md
DCT_BLOCK_SCHEDULER -- requirements
Module: dct_block_scheduler

Interface
REQ-001 The module SHALL use one clock, `clock`; reset is synchronous and active-high, named `reset`.
REQ-002 Parameter MAX_BLOCK_NUM SHALL default to 32 and sets the maximum number of blocks per run.
REQ-003 Parameter MAX_PIXEL_NUM SHALL default to 64 and sets the number of words per 8x8 block.
REQ-004 Parameter TIMEOUT_CYCLES SHALL default to 256 and sets the watchdog limit (REQ-027).
REQ-005 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request a run of block_num blocks
- block_num  in  6  number of blocks in the run; valid range 1..MAX_BLOCK_NUM
- busy  out  1  high whenever the FSM is not in IDLE
- load  out  1  one-cycle strobe: the array loader captures the block at base_addr
- block_index  out  5  current block number, 0..block_num-1
- base_addr  out  11  block_index*MAX_PIXEL_NUM
- dct_start  out  1  one-cycle strobe that starts the DCT
- dct_done  in  1  DCT completion pulse
- out_valid  out  1  DCT result for the current block is available
- out_ready  in  1  downstream accepts the result
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky watchdog flag

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD, KICK, WAIT_DCT, OUTPUT and FINISH.
REQ-007 In IDLE, start=1 with block_num in 1..MAX_BLOCK_NUM SHALL latch block_num, clear block_index to 0, and enter LOAD on the next edge.
REQ-008 In IDLE, start=1 with block_num=0 or block_num>MAX_BLOCK_NUM SHALL be ignored; the FSM stays in IDLE.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 LOAD SHALL assert load for exactly one cycle, then go to KICK.
REQ-011 KICK SHALL assert dct_start for exactly one cycle, then go to WAIT_DCT.
REQ-012 WAIT_DCT SHALL hold until dct_done=1, then go to OUTPUT.
REQ-013 dct_done SHALL be ignored outside WAIT_DCT.
REQ-014 OUTPUT SHALL hold out_valid=1 until out_valid and out_ready are both high on a clock edge.
REQ-015 On that handshake, if block_index=latched_num-1 the FSM SHALL go to FINISH; otherwise block_index SHALL increment and the FSM SHALL go to LOAD.
REQ-016 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be: start to load 1 cycle; load to dct_start 1 cycle; dct_done to out_valid 1 cycle; final handshake to done 1 cycle.
REQ-018 When out_ready is already high on OUTPUT entry, the handshake SHALL complete in one cycle.
REQ-019 base_addr SHALL be registered, updated together with block_index, and computed unsigned with no overflow (31*64=1984 < 2048).
REQ-020 block_index and base_addr SHALL remain stable from LOAD through the OUTPUT handshake.
REQ-021 latched_num SHALL not change during a run, regardless of later block_num changes.

Reset
REQ-022 With reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-023 Reset SHALL clear block_index, base_addr, latched_num, the watchdog counter and error to 0.
REQ-024 Reset SHALL drive load, dct_start, out_valid, done and busy to 0 from the following cycle.
REQ-025 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 With macro DCT_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT_DCT; if TIMEOUT_CYCLES elapse without dct_done, error SHALL be set (sticky until reset) and the FSM SHALL return to IDLE with no done pulse.
REQ-028 Without DCT_SCHED_TIMEOUT_EN, no counter SHALL be built, error SHALL be tied to 0, and WAIT_DCT SHALL wait indefinitely.

Verification
REQ-029 A bench SHALL check: block_num=3, start pulse, dct_done 5 cycles after each dct_start, out_ready=1 -> three load pulses with base_addr 0, 64, 128; done once; busy then low.
REQ-030 A bench SHALL check: block_num=0, start -> busy stays 0 and no load pulse.
REQ-031 A bench SHALL check: block_num=2, out_ready held 0 for 4 cycles in OUTPUT -> out_valid high for 4+1 cycles, block_index stays 0, then moves to 1.
REQ-032 A bench SHALL check: start pulsed during WAIT_DCT, and dct_done pulsed in IDLE -> both ignored; block count and done timing unchanged.
REQ-033 A bench SHALL check: reset asserted in WAIT_DCT of block 1 -> next cycle all outputs 0, no done; a new start with block_num=1 completes normally.
REQ-034 A bench SHALL check, with DCT_SCHED_TIMEOUT_EN defined: no dct_done for 256 cycles -> error=1, FSM in IDLE, error held until reset.
